// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// Fixed 34-cycle latency for legal operations; illegal ops and divide-by-zero complete in one cycle.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  FlagsE,
    input  logic        FlushE,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ResultLo,
    output logic [31:0] ResultHi,
    output logic [3:0]  MDFlags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULL = 3'b001;
    localparam logic [2:0] OP_SMULL = 3'b010;
    localparam logic [2:0] OP_UDIV  = 3'b100;
    localparam logic [2:0] OP_SDIV  = 3'b101;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [1:0]  cv_q;
    logic [31:0] a_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [4:0]  cnt_q;
    logic        neg_lo_q;
    logic        neg_hi_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] res_lo_q;
    logic [31:0] res_hi_q;
    logic [3:0]  flags_q;

    // Only C and V are carried through; N and Z are recomputed from the result.
    logic unused_flags;
    assign unused_flags = &{1'b0, FlagsE[3:2]};

    logic        op_legal;
    logic        op_signed;
    logic        op_div;
    logic        div_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        op_legal  = (Op == OP_MUL) || (Op == OP_UMULL) || (Op == OP_SMULL) ||
                    (Op == OP_UDIV) || (Op == OP_SDIV);
        op_signed = (Op == OP_SMULL) || (Op == OP_SDIV);
        op_div    = (Op == OP_UDIV) || (Op == OP_SDIV);
        div_zero  = op_div && (SrcB == 32'd0);
        abs_a     = (op_signed && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
        abs_b     = (op_signed && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;
    end

    // One iteration: hi/lo hold partial product (multiply) or remainder/dividend-quotient (divide).
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_diff  = div_shift - {1'b0, a_q};
        hi_d      = mul_sum[32:1];
        lo_d      = {mul_sum[0], lo_q[31:1]};
        if (op_q[2]) begin
            if (!div_diff[32]) begin
                hi_d = div_diff[31:0];
                lo_d = {lo_q[30:0], 1'b1};
            end else begin
                hi_d = div_shift[31:0];
                lo_d = {lo_q[30:0], 1'b0};
            end
        end
    end

    logic [63:0] prod;
    logic [63:0] prod_neg;
    logic [31:0] fix_lo_d;
    logic [31:0] fix_hi_d;
    logic [3:0]  fix_flags_d;
    logic        fix_long;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_neg = ~prod + 64'd1;
        fix_long = (op_q == OP_UMULL) || (op_q == OP_SMULL);
        fix_lo_d = lo_q;
        fix_hi_d = hi_q;
        case (op_q)
            OP_MUL: begin
                fix_lo_d = lo_q;
                fix_hi_d = 32'd0;
            end
            OP_SMULL: begin
                fix_lo_d = neg_lo_q ? prod_neg[31:0]  : prod[31:0];
                fix_hi_d = neg_lo_q ? prod_neg[63:32] : prod[63:32];
            end
            OP_SDIV: begin
                fix_lo_d = neg_lo_q ? (~lo_q + 32'd1) : lo_q;
                fix_hi_d = neg_hi_q ? (~hi_q + 32'd1) : hi_q;
            end
            default: begin
                fix_lo_d = lo_q;
                fix_hi_d = hi_q;
            end
        endcase
        fix_flags_d[3] = fix_long ? fix_hi_d[31] : fix_lo_d[31];
        fix_flags_d[2] = fix_long ? ({fix_hi_d, fix_lo_d} == 64'd0) : (fix_lo_d == 32'd0);
        fix_flags_d[1:0] = cv_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            cv_q     <= 2'd0;
            a_q      <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            cnt_q    <= 5'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            flags_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            if (FlushE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        state_q <= S_IDLE;
                        if (Start) begin
                            if (!op_legal || div_zero) begin
                                // Illegal op and divide-by-zero both report quotient 0, so N=0, Z=1.
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                                res_lo_q <= 32'd0;
                                res_hi_q <= op_legal ? SrcA : 32'd0;
                                flags_q  <= {2'b01, FlagsE[1:0]};
                            end else begin
                                state_q  <= S_CALC;
                                busy_q   <= 1'b1;
                                op_q     <= Op;
                                cv_q     <= FlagsE[1:0];
                                cnt_q    <= 5'd0;
                                hi_q     <= 32'd0;
                                a_q      <= op_div ? abs_b : abs_a;
                                lo_q     <= op_div ? abs_a : abs_b;
                                neg_lo_q <= op_signed && (SrcA[31] ^ SrcB[31]);
                                neg_hi_q <= (Op == OP_SDIV) && SrcA[31];
                            end
                        end
                    end
                    S_CALC: begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        res_lo_q <= fix_lo_d;
                        res_hi_q <= fix_hi_d;
                        flags_q  <= fix_flags_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign ResultLo = res_lo_q;
    assign ResultHi = res_hi_q;
    assign MDFlags  = flags_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit in the execute stage of the pipelined core. It runs alongside the ALU and, on completion, supplies its result and NZCV flags to the execute-stage condition/flag logic in place of ALUFlags. While an operation is in flight it drives a stall request to the hazard unit. Operations use radix-2, one bit per cycle, with a fixed latency so that hazard handling stays deterministic.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when the unit is accepting, which is state IDLE or DONE.
- Op  in  3  000 MUL (low 32), 001 UMULL, 010 SMULL, 100 UDIV, 101 SDIV; any other code is illegal.
- SrcA  in  32  multiplicand / dividend.
- SrcB  in  32  multiplier / divisor.
- FlagsE  in  4  current NZCV; bits [1:0] (C,V) are captured at accept.
- FlushE  in  1  abort the in-flight operation (execute-stage flush).
- Busy  out  1  stall request; high in CALC and FIX.
- Done  out  1  one-cycle pulse; results valid this cycle.
- ResultLo  out  32  MUL/long-mul low word, or quotient.
- ResultHi  out  32  long-mul high word, or remainder (0 for MUL).
- MDFlags  out  4  {N,Z,C,V} for the completed operation.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE/DONE → CALC.** Start=1, FlushE=0, Op legal, and not a division by zero. At accept:
  - latch Op and FlagsE[1:0];
  - latch operand magnitudes (absolute values for SMULL/SDIV) and the result signs;
  - set the iteration count to 0.
- **CALC.**
  - Each cycle performs one shift-add (multiply) or one restoring shift-subtract (divide), then count++.
  - Leave for FIX after the count-31 iteration, i.e. after 32 cycles.
- **FIX.** One cycle:
  - apply sign correction: two's-complement negate of the 64-bit product, or of the quotient/remainder;
  - the remainder takes the sign of the dividend;
  - compute flags. Next state: DONE.
- **DONE.** Done=1 for exactly one cycle. Next state: IDLE, or CALC if a new Start is accepted.
- **Early completion: IDLE/DONE → DONE**, taken on Start for:
  - an illegal Op: results 0, MDFlags {0,1,C,V};
  - UDIV/SDIV with SrcB=0: quotient 0, remainder SrcA.
- **SDIV overflow.** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, via the normal path with no special case.
- **Flags.**
  - N = ResultHi[31] for UMULL/SMULL, otherwise ResultLo[31].
  - Z = (64-bit result == 0) for long multiplies, otherwise (ResultLo == 0).
  - C,V = the values captured at accept.
- **Outputs.** ResultLo, ResultHi and MDFlags are registered and hold from DONE until the next FIX or early completion.
- **Flush.** FlushE=1 in any state returns the unit to IDLE on the next edge. There is no Done and the outputs are unchanged. FlushE has priority over a simultaneous Start, so the Start is not accepted.
- **Reset.** The unit enters IDLE; Busy=0, Done=0, ResultLo=0, ResultHi=0, MDFlags=0, count=0.
- **Start while Busy** is ignored; the operands are not re-sampled.

## Timing
- Start accepted at edge n:
  - CALC in cycles n+1 … n+32;
  - FIX in cycle n+33;
  - DONE (Done=1) in cycle n+34.
- Latency is 34 cycles for every legal op, independent of operand values.
- Early completion has Done in cycle n+1; Busy stays 0 throughout.
- Busy is 1 for exactly 33 cycles per normal operation. It is registered, not combinational from Start.
- The hazard unit inserts the first stall cycle itself in the Start cycle.
- Back-to-back: a Start in the DONE cycle is accepted, and Busy rises in the next cycle.
- Reset asserted mid-CALC: the next cycle is IDLE with all outputs at their reset values. A Start in the same cycle as reset is ignored.

## Test plan
- **UMULL** 0xFFFFFFFF × 0xFFFFFFFF, FlagsE=0011 → Done at n+34; ResultHi=0xFFFFFFFE, ResultLo=0x00000001; MDFlags=1011.
- **SMULL** 0xFFFFFFFE (−2) × 0x00000003 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, N=1, Z=0. Then MUL 0x10000 × 0x10000 → Lo=0, Hi=0, Z=1.
- **SDIV** 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. SDIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- **UDIV** 100 / 0 → Done at n+1, quotient 0, remainder 100, Busy never high. Op=011 → Done at n+1, results 0, Z=1.
- **FlushE** at n+10 of a UDIV → IDLE at n+11, Busy=0, no Done pulse, previous results retained. Start with FlushE in the same cycle → not accepted.
- **Back-to-back** MUL then UDIV, with the second Start in the DONE cycle → second Done exactly 34 cycles later. Reset at n+20 → all outputs 0 next cycle.
